comm_tx_framer: RTL
===================

Name: comm_tx_framer

Overview:
- Frame source directly upstream of the transmit chain (comm_send); drives its 32-bit valid/data/ack word interface.
- On start, reads a payload of len words from a synchronous payload RAM and emits one frame:
  - PREAMBLE_WORDS preamble words
  - one sync word
  - one header word
  - the payload
  - one CRC word
- Single clock domain; one frame in flight at a time.

Parameters:
ADDR_W, 8, payload RAM address width; max payload 2^ADDR_W-1 words
PREAMBLE_WORDS, 2, number of preamble words (1..15)
PREAMBLE, 32'hAAAA_AAAA, preamble word value
SYNC, 32'h1ACF_FC1D, sync word value

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
start  in  1  frame request pulse; sampled only in IDLE
len  in  ADDR_W  payload word count, captured when start is accepted
busy  out  1  high from cycle after accepted start until DONE completes
done  out  1  one-cycle pulse after CRC word acked
mem_rd_en  out  1  payload RAM read enable
mem_addr  out  ADDR_W  payload RAM address, base 0
mem_data  in  32  RAM read data, valid 1 cycle after mem_rd_en
valid_o  out  1  word available
data_o  out  32  word, stable while valid_o high
ack_o  in  1  consumer took word (single-cycle pulse from comm_send)

Behaviour:
- Reset: async on RST low. While RST low, all outputs are held 0 and the FSM is in IDLE. This includes valid_o, data_o, busy, done, mem_rd_en, mem_addr, and the seq counter. Reset mid-frame aborts the frame with no done pulse.
- Handshake:
  - valid_o and data_o are registered.
  - A word is consumed on a cycle where valid_o=1 and ack_o=1. ack_o while valid_o=0 is ignored.
  - After consumption, valid_o drops the next cycle unless the next word is already loaded. Preamble, sync, header and CRC words reload in the same edge, so they are gapless. Payload words have a 1-cycle gap for the RAM fetch.
- FSM states: IDLE, PRE, SYNC, HDR, FETCH, PAY, CRC, DONE.
  - IDLE: start=1 captures len and goes to PRE. valid_o becomes 1 with PREAMBLE the next cycle. The preamble count is cleared.
  - PRE: on ack, count++. After PREAMBLE_WORDS acks, go to SYNC with data_o=SYNC.
  - SYNC: on ack, go to HDR with data_o = {8'h00, seq[7:0], 8'h00, len zero-extended to 8 bits}. For ADDR_W>8, the low byte is len[7:0] and the top byte is len[15:8].
  - HDR: on ack, if len=0 go to CRC; else assert mem_rd_en with mem_addr=0 and go to FETCH.
  - FETCH: valid_o=0 for exactly one cycle. Then mem_data loads into data_o, valid_o=1, and the state goes to PAY.
  - PAY: on ack, if the word index equals len-1, go to CRC. Otherwise increment mem_addr, pulse mem_rd_en, and go to FETCH.
  - CRC: present the final CRC with valid_o=1. On ack go to DONE.
  - DONE: pulse done for one cycle, increment seq (wraps 255 to 0), drop busy, go to IDLE.
- start outside IDLE is ignored. start coincident with DONE is ignored.
- mem_rd_en pulses exactly once per payload word, in the cycle before FETCH.
- CRC: CRC-32/MPEG-2 over the header word and the payload words, in order.
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR.
  - Each word is processed as 4 bytes, MSB byte first.
  - The CRC register is re-initialised on start acceptance and updated on the ack of each header or payload word.
  - The CRC word value equals the register after the last payload ack (header only when len=0).
- No backpressure timeout: the FSM waits indefinitely for ack_o.

Decomposition:
- Shared package comm_pkg holds:
  - FSM state encoding
  - default PREAMBLE/SYNC constants
  - CRC32 polynomial/init constants
- One sub-module: crc32_d32 is a combinational next-CRC over a 32-bit data word and the current CRC. It is reused by the receive side.

Test Plan:
- len=0, seq=0, immediate acks -> AAAAAAAA, AAAAAAAA, 1ACFFC1D, 00000000, CRC(header) from model; done 1 cycle after final ack; busy 0 after.
- len=3, RAM[0..2]=11111111, 22222222, 33333333, ack 2 cycles after each valid -> exact word order; mem_rd_en 3 pulses at addr 0, 1, 2; one-cycle valid gap before each payload; CRC matches model.
- Two back-to-back frames, start pulsed during busy -> extra start ignored; second header = 00010000|len; seq wraps 255 to 0 after 256 frames.
- ack_o held high continuously, len=4 -> each word consumed exactly once; no skipped or duplicated payload words.
- RST low mid-PAY -> valid_o, busy, mem_rd_en 0 asynchronously, no done; next start produces full frame with seq=0.
- Spurious ack_o during FETCH/IDLE -> no state change; data_o stable while valid_o high and ack_o low for 20 cycles.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared types and constants for the comm framing blocks (transmit and receive sides).
package comm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SYNC,
        ST_HDR,
        ST_FETCH,
        ST_PAY,
        ST_CRC,
        ST_DONE
    } tx_state_e;

    localparam logic [31:0] COMM_PREAMBLE = 32'hAAAA_AAAA;
    localparam logic [31:0] COMM_SYNC     = 32'h1ACF_FC1D;

    // CRC-32/MPEG-2: MSB-first, no reflection, no final XOR
    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/comm_tx_framer_if.sv
// 32-bit valid/data/ack word link between the frame source and the transmit chain.
interface comm_tx_framer_if;

    logic        valid_o;
    logic [31:0] data_o;
    logic        ack_o;

    modport master (
        output valid_o,
        output data_o,
        input  ack_o
    );

    modport slave (
        input  valid_o,
        input  data_o,
        output ack_o
    );

endinterface

// File: rtl/crc32_d32.sv
// Combinational next-CRC over one 32-bit word, MSB first; shared with the receive side.
module crc32_d32
    import comm_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [31:0] i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_c;
    logic [31:0] w_d;

    always_comb begin
        w_c = i_crc;
        w_d = i_data;
        for (int unsigned i = 0; i < 32; i++) begin
            if (w_c[31] ^ w_d[31]) begin
                w_c = (w_c << 1) ^ CRC32_POLY;
            end else begin
                w_c = w_c << 1;
            end
            w_d = w_d << 1;
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/comm_tx_framer.sv
// Frame source: preamble, sync, header, payload from a sync RAM, then CRC-32/MPEG-2.
module comm_tx_framer
    import comm_pkg::*;
#(
    parameter int unsigned  ADDR_W         = 8,
    parameter int unsigned  PREAMBLE_WORDS = 2,
    parameter logic [31:0]  PREAMBLE       = COMM_PREAMBLE,
    parameter logic [31:0]  SYNC           = COMM_SYNC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    comm_tx_framer_if.master  tx
);

    localparam logic [3:0] LAST_PRE = 4'(PREAMBLE_WORDS - 1);

    tx_state_e         r_state, w_state_nxt;
    logic              r_valid, w_valid_nxt;
    logic [31:0]       r_data,  w_data_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;
    logic [3:0]        r_cnt,   w_cnt_nxt;
    logic [ADDR_W-1:0] r_len,   w_len_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [7:0]        r_seq,   w_seq_nxt;
    logic [31:0]       r_crc,   w_crc_nxt;

    logic              w_fire;
    logic              w_last;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [15:0]       w_len16;
    logic [31:0]       w_hdr;
    logic [31:0]       w_crc_upd;

    assign w_fire  = r_valid & tx.ack_o;
    assign w_last  = (r_addr == r_len - ADDR_W'(1));
    assign w_len16 = 16'(r_len);
    assign w_hdr   = {w_len16[15:8], r_seq, 8'h00, w_len16[7:0]};

    // Only header and payload words feed the CRC, so the word on the bus is the input.
    crc32_d32 u_crc (
        .i_crc  (r_crc),
        .i_data (r_data),
        .o_crc  (w_crc_upd)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_seq   <= '0;
            r_crc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_addr  <= w_addr_nxt;
            r_seq   <= w_seq_nxt;
            r_crc   <= w_crc_nxt;
        end
    end

    // RAM read is issued combinationally in the ack cycle so the fetch gap is one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_addr_nxt  = r_addr;
        w_seq_nxt   = r_seq;
        w_crc_nxt   = r_crc;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_addr;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_PRE;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = PREAMBLE;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_len_nxt   = len;
                    w_addr_nxt  = '0;
                    w_crc_nxt   = CRC32_INIT;
                end
            end
            ST_PRE: begin
                if (w_fire) begin
                    if (r_cnt == LAST_PRE) begin
                        w_state_nxt = ST_SYNC;
                        w_data_nxt  = SYNC;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            ST_SYNC: begin
                if (w_fire) begin
                    w_state_nxt = ST_HDR;
                    w_data_nxt  = w_hdr;
                end
            end
            ST_HDR: begin
                if (w_fire) begin
                    w_crc_nxt = w_crc_upd;
                    if (r_len == '0) begin
                        w_state_nxt = ST_CRC;
                        w_data_nxt  = w_crc_upd;
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_valid_nxt = 1'b0;
                        w_rd_en     = 1'b1;
                        w_rd_addr   = '0;
                        w_addr_nxt  = '0;
                    end
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_PAY;
                w_valid_nxt = 1'b1;
                w_data_nxt  = mem_data;
            end
            ST_PAY: begin
                if (w_fire) begin
                    w_crc_nxt = w_crc_upd;
                    if (w_last) begin
                        w_state_nxt = ST_CRC;
                        w_data_nxt  = w_crc_upd;
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_valid_nxt = 1'b0;
                        w_rd_en     = 1'b1;
                        w_rd_addr   = r_addr + ADDR_W'(1);
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                    end
                end
            end
            ST_CRC: begin
                if (w_fire) begin
                    w_state_nxt = ST_DONE;
                    w_valid_nxt = 1'b0;
                    w_data_nxt  = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_seq_nxt   = r_seq + 8'd1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign mem_rd_en  = w_rd_en;
    assign mem_addr   = w_rd_addr;
    assign tx.valid_o = r_valid;
    assign tx.data_o  = r_data;

endmodule
